// File: rtl/match_controller.sv
// Match sequencing for a two-player paddle game: button strobes, tick prescaler, serve delay and scoring.
// Optional pause feature enabled by defining MATCH_CONTROLLER_PAUSE_EN.
module match_controller #(
    parameter int TICK_DIV    = 833_333,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       point_left,
    input  logic       point_right,
    output logic [1:0] state,
    output logic       timing_tick,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       serve_right,
    output logic       winner_right
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(SERVE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SERVE_LOAD = SW'(SERVE_TICKS);
    localparam logic [3:0]    WIN4       = 4'(WIN_SCORE);

    // PAUSED shares the low bits of HOLD so the phase output is a plain slice of the register
    typedef enum logic [2:0] {
        MENU   = 3'b000,
        PLAY   = 3'b001,
        OVER   = 3'b010,
        HOLD   = 3'b011,
        PAUSED = 3'b111
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc;
    logic            raw_tick;
    logic [SW-1:0]   serve_cnt, serve_cnt_d;
    logic [3:0]      score_l, score_l_d, score_r, score_r_d;
    logic [3:0]      score_l_inc, score_r_inc;
    logic            serve_r, serve_r_d, win_r, win_r_d, tick_q;

    logic [1:0]      sync_fill;
    logic [1:0]      start_sync;
    logic            start_prev, start_armed, start_strobe;

    // A button only arms once a genuine low sample has been seen, so a press held through reset is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_fill   <= '0;
            start_sync  <= '0;
            start_prev  <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            sync_fill  <= {sync_fill[0], 1'b1};
            start_sync <= {start_sync[0], start_btn};
            start_prev <= start_sync[1];
            if (sync_fill[1] && !start_sync[1])
                start_armed <= 1'b1;
        end
    end

    assign start_strobe = start_sync[1] & ~start_prev & start_armed;

`ifdef MATCH_CONTROLLER_PAUSE_EN
    logic [1:0] pause_sync;
    logic       pause_prev, pause_armed, pause_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_sync  <= '0;
            pause_prev  <= 1'b0;
            pause_armed <= 1'b0;
        end else begin
            pause_sync <= {pause_sync[0], pause_btn};
            pause_prev <= pause_sync[1];
            if (sync_fill[1] && !pause_sync[1])
                pause_armed <= 1'b1;
        end
    end

    assign pause_strobe = pause_sync[1] & ~pause_prev & pause_armed;
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (presc == PRESC_LAST)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    assign raw_tick    = (presc == PRESC_LAST);
    assign score_l_inc = score_l + 4'd1;
    assign score_r_inc = score_r + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MENU;
            serve_cnt <= '0;
            score_l   <= '0;
            score_r   <= '0;
            serve_r   <= 1'b0;
            win_r     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            serve_cnt <= serve_cnt_d;
            score_l   <= score_l_d;
            score_r   <= score_r_d;
            serve_r   <= serve_r_d;
            win_r     <= win_r_d;
            tick_q    <= raw_tick && (state_q == PLAY);
        end
    end

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt;
        score_l_d   = score_l;
        score_r_d   = score_r;
        serve_r_d   = serve_r;
        win_r_d     = win_r;
        case (state_q)
            MENU: begin
                score_l_d = '0;
                score_r_d = '0;
                if (start_strobe) begin
                    serve_cnt_d = SERVE_LOAD;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (raw_tick) begin
                    if (serve_cnt <= SW'(1)) begin
                        serve_cnt_d = '0;
                        state_d     = PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt - SW'(1);
                    end
                end
            end
            PLAY: begin
                // Left wins a simultaneous point; scores clamp at the winning value
                if (point_left) begin
                    serve_r_d = 1'b1;
                    if (score_l_inc >= WIN4) begin
                        score_l_d = WIN4;
                        win_r_d   = 1'b0;
                        state_d   = OVER;
                    end else begin
                        score_l_d   = score_l_inc;
                        serve_cnt_d = SERVE_LOAD;
                        state_d     = HOLD;
                    end
                end else if (point_right) begin
                    serve_r_d = 1'b0;
                    if (score_r_inc >= WIN4) begin
                        score_r_d = WIN4;
                        win_r_d   = 1'b1;
                        state_d   = OVER;
                    end else begin
                        score_r_d   = score_r_inc;
                        serve_cnt_d = SERVE_LOAD;
                        state_d     = HOLD;
                    end
                end
`ifdef MATCH_CONTROLLER_PAUSE_EN
                else if (pause_strobe) begin
                    state_d = PAUSED;
                end
`endif
            end
            OVER: begin
                if (start_strobe) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    state_d   = MENU;
                end
            end
`ifdef MATCH_CONTROLLER_PAUSE_EN
            PAUSED: begin
                if (pause_strobe)
                    state_d = PLAY;
            end
`endif
            default: state_d = MENU;
        endcase
    end

    assign state        = state_q[1:0];
    assign timing_tick  = tick_q;
    assign score_left   = score_l;
    assign score_right  = score_r;
    assign serve_right  = serve_r;
    assign winner_right = win_r;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: every change of the phase/score outputs is matched against a queue of expected snapshots.
module tb_match_controller;

    localparam int TD = 4;
    localparam int ST = 2;
    localparam int WS = 3;

    localparam logic [1:0] S_MENU = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_OVER = 2'b10;
    localparam logic [1:0] S_HOLD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       point_left = 1'b0;
    logic       point_right = 1'b0;
    logic [1:0] state;
    logic       timing_tick;
    logic [3:0] score_left, score_right;
    logic       serve_right, winner_right;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       sv;
        logic       wn;
    } exp_t;

    exp_t expq[$];

    match_controller #(.TICK_DIV(TD), .SERVE_TICKS(ST), .WIN_SCORE(WS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_btn    (start_btn),
        .pause_btn    (pause_btn),
        .point_left   (point_left),
        .point_right  (point_right),
        .state        (state),
        .timing_tick  (timing_tick),
        .score_left   (score_left),
        .score_right  (score_right),
        .serve_right  (serve_right),
        .winner_right (winner_right)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic push_exp(input string name, input logic [1:0] st, input logic [3:0] sl,
                            input logic [3:0] sr, input logic sv, input logic wn);
        exp_t e;
        e.name = name; e.st = st; e.sl = sl; e.sr = sr; e.sv = sv; e.wn = wn;
        expq.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Buttons are held for two cycles (one clean edge); point inputs are single-cycle pulses
    task automatic applyStimulus(input string what);
        case (what)
            "start": begin start_btn = 1'b1; step(2); start_btn = 1'b0; end
            "pause": begin pause_btn = 1'b1; step(2); pause_btn = 1'b0; end
            "left":  begin point_left = 1'b1; step(1); point_left = 1'b0; end
            "right": begin point_right = 1'b1; step(1); point_right = 1'b0; end
            "both":  begin point_left = 1'b1; point_right = 1'b1; step(1);
                           point_left = 1'b0; point_right = 1'b0; end
            default: $display("[TB] unknown stimulus %s", what);
        endcase
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string name, output int cycles);
        cycles = 0;
        while (state !== s && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(name, state, s);
        #1;
    endtask

    // Output monitor: each change of the registered outputs consumes one expected snapshot
    logic [11:0] prev_tuple;
    bit          first = 1'b1;

    always @(negedge clk) begin
        logic [11:0] cur;
        exp_t        e;
        cur = {state, score_left, score_right, serve_right, winner_right};
        if (first || cur !== prev_tuple) begin
            first      = 1'b0;
            prev_tuple = cur;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_change: got %03h, expected no change", cur);
            end else begin
                e = expq.pop_front();
                checkOutput({e.name, "/state"},  state,        e.st);
                checkOutput({e.name, "/left"},   score_left,   e.sl);
                checkOutput({e.name, "/right"},  score_right,  e.sr);
                checkOutput({e.name, "/serve"},  serve_right,  e.sv);
                checkOutput({e.name, "/winner"}, winner_right, e.wn);
            end
        end
    end

    // Tick reference: the prescaler restarts at reset release, so a tick appears every TD edges while in PLAY
    int         edges;
    logic [1:0] prev_state = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(negedge clk) begin
        logic exp_tick;
        if (!rst_n) begin
            prev_state = 2'b00;
        end else begin
            exp_tick = (edges != 0) && (edges % TD == 0) && (prev_state == S_PLAY);
            if (exp_tick || timing_tick)
                checkOutput("timing_tick", timing_tick, exp_tick);
            prev_state = state;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cyc;
        push_exp("reset", S_MENU, 0, 0, 0, 0);
        step(3);
        rst_n = 1'b1;
        step(4);

        // First serve: HOLD lasts exactly SERVE_TICKS ticks
        push_exp("start_hold", S_HOLD, 0, 0, 0, 0);
        push_exp("first_play", S_PLAY, 0, 0, 0, 0);
        applyStimulus("start");
        wait_state(S_HOLD, 10, "reach_hold", cyc);
        wait_state(S_PLAY, 20, "reach_play", cyc);
        checkOutput("hold_len_min", (cyc >= 5), 1);
        checkOutput("hold_len_max", (cyc <= 8), 1);
        step(9);

        push_exp("left1_hold", S_HOLD, 1, 0, 1, 0);
        push_exp("left1_play", S_PLAY, 1, 0, 1, 0);
        applyStimulus("left");
        applyStimulus("right");
        wait_state(S_PLAY, 20, "play_after_left1", cyc);

        push_exp("left2_hold", S_HOLD, 2, 0, 1, 0);
        push_exp("left2_play", S_PLAY, 2, 0, 1, 0);
        applyStimulus("left");
        wait_state(S_PLAY, 20, "play_after_left2", cyc);

        push_exp("right1_hold", S_HOLD, 2, 1, 0, 0);
        push_exp("right1_play", S_PLAY, 2, 1, 0, 0);
        applyStimulus("right");
        wait_state(S_PLAY, 20, "play_after_right1", cyc);

        push_exp("left_win", S_OVER, 3, 1, 1, 0);
        applyStimulus("left");
        step(12);
        checkOutput("left_win_winner", winner_right, 0);

        push_exp("over_to_menu", S_MENU, 0, 0, 1, 0);
        applyStimulus("start");
        wait_state(S_MENU, 10, "reach_menu", cyc);
        step(3);

        push_exp("game2_hold", S_HOLD, 0, 0, 1, 0);
        push_exp("game2_play", S_PLAY, 0, 0, 1, 0);
        applyStimulus("start");
        wait_state(S_PLAY, 20, "game2_play_wait", cyc);

        push_exp("g2_right_hold", S_HOLD, 0, 1, 0, 0);
        push_exp("g2_right_play", S_PLAY, 0, 1, 0, 0);
        applyStimulus("right");
        wait_state(S_PLAY, 20, "g2_right_wait", cyc);

        push_exp("both_hold", S_HOLD, 1, 1, 1, 0);
        push_exp("both_play", S_PLAY, 1, 1, 1, 0);
        applyStimulus("both");
        checkOutput("both_left", score_left, 1);
        checkOutput("both_right", score_right, 1);
        wait_state(S_PLAY, 20, "both_wait", cyc);

`ifdef MATCH_CONTROLLER_PAUSE_EN
        push_exp("paused", S_HOLD, 1, 1, 1, 0);
        push_exp("resumed", S_PLAY, 1, 1, 1, 0);
        applyStimulus("pause");
        wait_state(S_HOLD, 10, "pause_enter", cyc);
        applyStimulus("left");
        step(10);
        checkOutput("paused_point_ignored", score_left, 1);
        applyStimulus("pause");
        wait_state(S_PLAY, 10, "pause_exit", cyc);
`else
        applyStimulus("pause");
        step(6);
        checkOutput("pause_ignored", state, S_PLAY);
`endif

        push_exp("g2_right2_hold", S_HOLD, 1, 2, 0, 0);
        push_exp("g2_right2_play", S_PLAY, 1, 2, 0, 0);
        applyStimulus("right");
        wait_state(S_PLAY, 20, "g2_right2_wait", cyc);

        push_exp("right_win", S_OVER, 1, 3, 0, 1);
        applyStimulus("right");
        step(6);

        push_exp("g2_menu", S_MENU, 0, 0, 0, 1);
        applyStimulus("start");
        wait_state(S_MENU, 10, "g2_menu_wait", cyc);
        step(3);

        push_exp("game3_hold", S_HOLD, 0, 0, 0, 1);
        push_exp("game3_play", S_PLAY, 0, 0, 0, 1);
        applyStimulus("start");
        wait_state(S_PLAY, 20, "game3_play_wait", cyc);
        step(3);

        // Asynchronous reset mid-PLAY, with start held through the release
        push_exp("mid_reset", S_MENU, 0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        start_btn = 1'b1;
        #1;
        checkOutput("rst_state", state, S_MENU);
        checkOutput("rst_left", score_left, 0);
        checkOutput("rst_right", score_right, 0);
        checkOutput("rst_serve", serve_right, 0);
        checkOutput("rst_winner", winner_right, 0);
        checkOutput("rst_tick", timing_tick, 0);
        step(3);
        rst_n = 1'b1;
        step(10);
        start_btn = 1'b0;
        step(4);
        checkOutput("held_start_no_strobe", state, S_MENU);
        checkOutput("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter TICK_DIV, default 833_333, clk cycles per game tick (must be >= 2).
REQ-002 Parameter SERVE_TICKS, default 60, game ticks spent in HOLD before each serve (must be >= 1).
REQ-003 Parameter WIN_SCORE, default 9, points that end the match (range 1..15).
REQ-004 Port clk, input, 1, system clock; the block has exactly one clock.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port start_btn, input, 1, asynchronous level from the start button.
REQ-007 Port pause_btn, input, 1, asynchronous level from the pause button; used only with PAUSE_EN.
REQ-008 Port point_left, input, 1, one-cycle pulse: the left player scored.
REQ-009 Port point_right, input, 1, one-cycle pulse: the right player scored.
REQ-010 Port state, output, 2, match phase: MENU=00, PLAY=01, GAME_OVER=10, HOLD=11.
REQ-011 Port timing_tick, output, 1, one-cycle ball-advance strobe.
REQ-012 Port score_left, output, 4, left player's score.
REQ-013 Port score_right, output, 4, right player's score.
REQ-014 Port serve_right, output, 1, serve direction for the next serve: 1 = toward the right.
REQ-015 Port winner_right, output, 1, valid in GAME_OVER: 1 = the right player won.

Function
REQ-016 start_btn and pause_btn shall each pass through a 2-FF synchronizer and a rising-edge detector; each press yields exactly one cycle of press strobe, and all rules below act on that strobe.
REQ-017 A free-running prescaler shall count 0..TICK_DIV-1 and wrap to 0; the cycle in which it equals TICK_DIV-1 is the raw tick.
REQ-018 timing_tick shall be registered and shall pulse for one cycle, one cycle after each raw tick that occurs while state==PLAY; it shall stay 0 in every other state.
REQ-019 MENU: scores shall be held at 0; a start strobe shall load the serve counter with SERVE_TICKS and move to HOLD.
REQ-020 HOLD: the serve counter shall decrement on each raw tick; the raw tick that brings it to 0 shall move the block to PLAY; start strobes shall be ignored.
REQ-021 PLAY, point_left: score_left shall increment and serve_right shall become 1; if the new score equals WIN_SCORE the block shall move to GAME_OVER with winner_right=0, otherwise it shall reload the serve counter and move to HOLD.
REQ-022 PLAY, point_right: the mirror of REQ-021 — score_right shall increment, serve_right shall become 0, and a win shall set winner_right=1.
REQ-023 point_left and point_right asserted in the same cycle: point_left shall be taken and point_right discarded.
REQ-024 Point pulses arriving in any state other than PLAY shall be ignored.
REQ-025 GAME_OVER: scores and winner_right shall hold; a start strobe shall clear both scores and move to MENU.
REQ-026 Scores shall never exceed WIN_SCORE and shall never wrap.
REQ-027 The state, score, serve_right and winner_right outputs shall be registered and shall change only on clk edges.

Reset
REQ-028 Asserting rst_n low at any time, including mid-HOLD or mid-PLAY, shall immediately force: state=MENU, prescaler=0, serve counter=0, timing_tick=0, both scores=0, serve_right=0, winner_right=0, and synchronizer/edge-detector stages=0.
REQ-029 A button held high through reset release shall not produce a strobe.

Configuration
REQ-030 With the macro MATCH_CONTROLLER_PAUSE_EN defined: a pause strobe in PLAY shall move to an internal PAUSED state (state output HOLD, no timing_tick); a pause strobe in PAUSED shall return to PLAY; point pulses in PAUSED shall be ignored; the prescaler shall keep running.
REQ-031 Without the macro: pause_btn shall be ignored, there shall be no PAUSED state, and all other behaviour shall be unchanged.

Verification (TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=3)
REQ-032 Reset, then one start press -> state=11; exactly 2 raw ticks later state=01; timing_tick pulses once every 4 clk cycles.
REQ-033 Three point_left pulses in PLAY, each after HOLD expires -> scores 1,2,3; after the third, state=10, winner_right=0, and timing_tick stays 0.
REQ-034 point_left and point_right in the same cycle -> score_left=1, score_right=0, serve_right=1.
REQ-035 point_right while state=11 -> scores unchanged; rst_n pulsed low mid-PLAY -> all outputs at reset values in the same cycle.
REQ-036 With MATCH_CONTROLLER_PAUSE_EN defined: pause press in PLAY -> state=11, no ticks, point ignored; second press -> state=01. Without the macro: pause press -> state remains 01.
